// File: rtl/crg_sync_pkg.sv
// rtl/crg_sync_pkg.sv - shared defaults, limits and widths for the multi-channel synchroniser
//
// Purpose: single source for parameter defaults, legal ranges and the glitch
// filter counter width used by crg_sync_multi and crg_sync_chan.
// Ports: none (package).

package crg_sync_pkg;

  localparam int WIDTH_DEF      = 1;
  localparam int WIDTH_MIN      = 1;
  localparam int WIDTH_MAX      = 32;

  localparam int STAGES_DEF     = 2;
  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 4;

  localparam int NEG_EDGE_DEF   = 0;

  localparam int FILTER_LEN_DEF = 0;
  localparam int FILTER_LEN_MAX = 15;

  // Filter counter width; FILTER_LEN_MAX-1 must fit.
  localparam int CNT_W          = 4;

  function automatic bit params_ok(input int width, input int stages,
                                   input int neg_edge, input int filter_len);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
           (neg_edge == 0 || neg_edge == 1) &&
           (filter_len >= 0) && (filter_len <= FILTER_LEN_MAX);
  endfunction

endpackage

// File: rtl/crg_sync_chan.sv
// rtl/crg_sync_chan.sv - one synchroniser channel: flop chain, glitch filter, edge detect
//
// Purpose: brings one asynchronous bit into the clk domain through a
// STAGES-deep chain, optionally requires FILTER_LEN consecutive differing
// samples before updating q, and flags rising/falling transitions of q.
// Ports:
//   clk    - active clock (already inverted by the top when falling-edge mode)
//   clr_n  - asynchronous active-low clear
//   d      - asynchronous data input
//   q      - synchronised, filtered output
//   q_rise - one-cycle pulse on q 0->1
//   q_fall - one-cycle pulse on q 1->0

module crg_sync_chan
  import crg_sync_pkg::*;
#(
  parameter int   STAGES     = STAGES_DEF,
  parameter int   FILTER_LEN = FILTER_LEN_DEF,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q,
  output logic q_rise,
  output logic q_fall
);

  logic [STAGES-1:0] chain;
  logic              s;
  logic              q_int;
  logic              q_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign s = chain[STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    assign q_int = s;
  end else begin : g_filter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic             q_reg;

    // Any sample that agrees with q restarts the run, so a pulse shorter
    // than FILTER_LEN edges never reaches q. cnt saturates at CNT_LAST.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        cnt   <= '0;
        q_reg <= RESET_VAL;
      end else if (s == q_reg) begin
        cnt <= '0;
      end else if (cnt < CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        q_reg <= s;
        cnt   <= '0;
      end
    end

    assign q_int = q_reg;
  end

  // q_d resets with q so releasing clr_n never produces an edge pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_d <= RESET_VAL;
    end else begin
      q_d <= q_int;
    end
  end

  assign q      = q_int;
  assign q_rise = q_int & ~q_d;
  assign q_fall = ~q_int & q_d;

endmodule

// File: rtl/m_inv.sv
// rtl/m_inv.sv - library inverter cell used to derive the falling-edge clock
//
// Purpose: behavioural model of the clock inverter cell.
// Ports:
//   a - input
//   y - inverted output

module m_inv (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/crg_sync_multi.sv
// rtl/crg_sync_multi.sv - WIDTH independent bit synchronisers with optional glitch filter
//
// Purpose: top level; selects the active clock edge and replicates
// crg_sync_chan per channel. Channels are independent: no bus coherency.
// Ports:
//   clk    - the only clock
//   clr_n  - asynchronous active-low clear
//   d      - [WIDTH] asynchronous data inputs
//   q      - [WIDTH] synchronised, filtered data
//   q_rise - [WIDTH] one-cycle pulse on each q 0->1
//   q_fall - [WIDTH] one-cycle pulse on each q 1->0

module crg_sync_multi
  import crg_sync_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               STAGES      = STAGES_DEF,
  parameter int               NEG_EDGE    = NEG_EDGE_DEF,
  parameter logic [WIDTH-1:0] RESET_STATE = {WIDTH{1'b0}},
  parameter int               FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  if (!params_ok(WIDTH, STAGES, NEG_EDGE, FILTER_LEN)) begin : g_param_err
    $error("crg_sync_multi: parameter out of range");
  end

  logic clk_act;

  // Falling-edge mode runs every flop off the library inverter output so
  // the channel logic is always written against a rising edge.
  if (NEG_EDGE == 1) begin : g_neg
    m_inv u_inv (
      .a (clk),
      .y (clk_act)
    );
  end else begin : g_pos
    assign clk_act = clk;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    crg_sync_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_STATE[i])
    ) u_chan (
      .clk    (clk_act),
      .clr_n  (clr_n),
      .d      (d[i]),
      .q      (q[i]),
      .q_rise (q_rise[i]),
      .q_fall (q_fall[i])
    );
  end

endmodule
